// File: rtl/mult_booth_pkg.sv
// Shared definitions for the sequential Booth multiplier: operand width,
// step count, counter width and the controller state encoding.
package mult_booth_pkg;

    localparam int WIDTH      = 32;
    localparam int MULT_STEPS = 32;
    localparam int CNT_W      = 6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mult_booth_booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of the multiplicand
// followed by an arithmetic right shift of {A, Q, Qm1}.
module booth_step
    import mult_booth_pkg::*;
(
    input  logic [WIDTH:0]   i_a,
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_qm1,
    input  logic [WIDTH:0]   i_m,
    output logic [WIDTH:0]   o_a,
    output logic [WIDTH-1:0] o_q,
    output logic             o_qm1
);

    logic [WIDTH:0] w_sum;

    always_comb begin
        // NOTE: w_sum gets a default before the case so no path leaves it unassigned (no latch).
        w_sum = i_a;
        case ({i_q[0], i_qm1})
            2'b01:   w_sum = i_a + i_m;
            2'b10:   w_sum = i_a - i_m;
            default: w_sum = i_a;
        endcase
    end

    // The 33rd accumulator bit carries the sign, so A - M stays exact for M = -2^31.
    assign o_a   = {w_sum[WIDTH], w_sum[WIDTH:1]};
    assign o_q   = {w_sum[0], i_q[WIDTH-1:1]};
    assign o_qm1 = i_q[0];

endmodule

// File: rtl/mult_booth.sv
// Sequential signed 32x32->64 Booth multiplier, one step per clock; publishes
// the product on Hi/Lo with a one-cycle done pulse.
module mult_booth
    import mult_booth_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] Multiplicando,
    input  logic [WIDTH-1:0] Multiplicador,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             done
);

    state_t           r_state;
    logic [WIDTH:0]   r_a;
    logic [WIDTH:0]   r_m;
    logic [WIDTH-1:0] r_q;
    logic             r_qm1;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH:0]   w_a_next;
    logic [WIDTH-1:0] w_q_next;
    logic             w_qm1_next;

    booth_step u_step (
        .i_a   (r_a),
        .i_q   (r_q),
        .i_qm1 (r_qm1),
        .i_m   (r_m),
        .o_a   (w_a_next),
        .o_q   (w_q_next),
        .o_qm1 (w_qm1_next)
    );

    // NOTE: all state uses non-blocking assignments; r_m is left out of reset because it is always loaded by start before use.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_q     <= '0;
            r_qm1   <= 1'b0;
            r_cnt   <= '0;
            Hi      <= '0;
            Lo      <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                r_m     <= {Multiplicando[WIDTH-1], Multiplicando};
                r_q     <= Multiplicador;
                r_a     <= '0;
                r_qm1   <= 1'b0;
                r_cnt   <= CNT_W'(MULT_STEPS);
                r_state <= S_RUN;
            end else begin
                case (r_state)
                    S_RUN: begin
                        r_a   <= w_a_next;
                        r_q   <= w_q_next;
                        r_qm1 <= w_qm1_next;
                        r_cnt <= r_cnt - CNT_W'(1);
                        // Last step: publish the post-shift product in one go.
                        if (r_cnt == CNT_W'(1)) begin
                            Hi      <= w_a_next[WIDTH-1:0];
                            Lo      <= w_q_next;
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                    S_DONE:  r_state <= S_IDLE;
                    S_IDLE:  r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
